// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with single-cycle logic/arith/shift ops and an iterative
// radix-2 shift-add multiplier. The multiplier holds off upstream through
// ready_o and reports busy_o to the hazard unit while it runs.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a new op; non-MUL ops complete on the next edge
// MUL    | shift-add iterations in progress; upstream is stalled
module alu_exec_unit #(
  parameter int WIDTH          = 32,
  parameter bit MUL_EARLY_EXIT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ALUCtl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             busy_o
);

  localparam logic [3:0] ALU_CTL_AND = 4'b0000;
  localparam logic [3:0] ALU_CTL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTL_XOR = 4'b0011;
  localparam logic [3:0] ALU_CTL_SLL = 4'b0100;
  localparam logic [3:0] ALU_CTL_SRA = 4'b0101;
  localparam logic [3:0] ALU_CTL_SUB = 4'b0110;
  localparam logic [3:0] ALU_CTL_MUL = 4'b1000;

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] mplier_shift;
  logic [CW-1:0]    cnt_step;
  logic             mul_done;
  logic [SHW-1:0]   shamt;

  assign ready_o  = (state_q == S_IDLE);
  assign busy_o   = (state_q == S_MUL);
  assign accept   = valid_i & ready_o & ~flush_i;
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign shamt    = data2_i[SHW-1:0];

  // Single-cycle operation results; unknown codes produce zero.
  always_comb begin
    alu_res = '0;
    case (ALUCtl_i)
      ALU_CTL_ADD: alu_res = data1_i + data2_i;
      ALU_CTL_SUB: alu_res = data1_i - data2_i;
      ALU_CTL_AND: alu_res = data1_i & data2_i;
      ALU_CTL_XOR: alu_res = data1_i ^ data2_i;
      ALU_CTL_SLL: alu_res = data1_i << shamt;
      ALU_CTL_SRA: alu_res = $signed(data1_i) >>> shamt;
      default:     alu_res = '0;
    endcase
  end

  // One shift-add iteration; completion looks at the post-shift multiplier.
  always_comb begin
    acc_step     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_shift = mplier_q >> 1;
    cnt_step     = cnt_q + CW'(1);
    mul_done     = (cnt_step == CW'(WIDTH)) ||
                   (MUL_EARLY_EXIT && (mplier_shift == '0));
  end

  // Next-state and datapath updates for the IDLE/MUL controller.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (ALUCtl_i == ALU_CTL_MUL) begin
            state_d  = S_MUL;
            mcand_d  = data1_i;
            mplier_d = data2_i;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            valid_d  = 1'b1;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
          end
        end
      end
      S_MUL: begin
        if (flush_i) begin
          // Aborted multiply: drop it silently, keep the last visible result.
          state_d = S_IDLE;
        end else begin
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_shift;
          acc_d    = acc_step;
          cnt_d    = cnt_step;
          if (mul_done) begin
            state_d  = S_IDLE;
            valid_d  = 1'b1;
            result_d = acc_step;
            zero_d   = (acc_step == '0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: two instances (multiplier early exit off/on) share
// operands, reset and flush, each with its own valid_i. A behavioural model
// predicts every output on every cycle; directed cases pin literal results.
module tb_alu_exec_unit;
  localparam int W = 32;
  localparam logic [3:0] C_AND = 4'h0, C_ADD = 4'h2, C_XOR = 4'h3, C_SLL = 4'h4;
  localparam logic [3:0] C_SRA = 4'h5, C_SUB = 4'h6, C_MUL = 4'h8, C_BAD = 4'hF;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         flush = 1'b0;
  logic [1:0]   vin = '0;
  logic [1:0]   ready, vout, zero, busy;
  logic [W-1:0] res [2];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [W-1:0] log_q [$];

  alu_exec_unit #(.WIDTH(W), .MUL_EARLY_EXIT(1'b0)) u0 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(vin[0]), .ready_o(ready[0]),
    .ALUCtl_i(op), .data1_i(a), .data2_i(b), .flush_i(flush),
    .valid_o(vout[0]), .result_o(res[0]), .zero_o(zero[0]), .busy_o(busy[0]));

  alu_exec_unit #(.WIDTH(W), .MUL_EARLY_EXIT(1'b1)) u1 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(vin[1]), .ready_o(ready[1]),
    .ALUCtl_i(op), .data1_i(a), .data2_i(b), .flush_i(flush),
    .valid_o(vout[1]), .result_o(res[1]), .zero_o(zero[1]), .busy_o(busy[1]));

  initial forever #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic logic [W-1:0] alu_ref(input logic [3:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic signed [W-1:0] s;
    logic [4:0] sh;
    s  = x;
    sh = y[4:0];
    case (o)
      C_ADD:   return x + y;
      C_SUB:   return x - y;
      C_AND:   return x & y;
      C_XOR:   return x ^ y;
      C_SLL:   return x << sh;
      C_SRA:   return s >>> sh;
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] mul_ref(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return p[W-1:0];
  endfunction

  // Busy cycles: all WIDTH bits, or just up to the top set multiplier bit (min 1).
  function automatic int mul_iters(input logic [W-1:0] y, input bit ee);
    int n;
    n = 0;
    if (!ee) return W;
    for (int k = 0; k < W; k++) if (y[k]) n = k + 1;
    return (n == 0) ? 1 : n;
  endfunction

  bit           m_mul   [2];
  int           m_left  [2];
  logic [W-1:0] m_prod  [2];
  bit           e_valid [2];
  logic [W-1:0] e_res   [2];
  bit           e_zero  [2];

  initial forever begin
    @(posedge clk_i or negedge rst_i);
    for (int i = 0; i < 2; i++) begin
      if (!rst_i) begin
        m_mul[i] = 0; m_left[i] = 0; m_prod[i] = '0;
        e_valid[i] = 0; e_res[i] = '0; e_zero[i] = 0;
      end else begin
        e_valid[i] = 0;
        if (m_mul[i]) begin
          if (flush) m_mul[i] = 0;
          else begin
            m_left[i]--;
            if (m_left[i] == 0) begin
              m_mul[i] = 0; e_valid[i] = 1;
              e_res[i] = m_prod[i]; e_zero[i] = (m_prod[i] == '0);
            end
          end
        end else if (vin[i] && !flush) begin
          if (op == C_MUL) begin
            m_mul[i] = 1; m_left[i] = mul_iters(b, i == 1); m_prod[i] = mul_ref(a, b);
          end else begin
            e_valid[i] = 1; e_res[i] = alu_ref(op, a, b); e_zero[i] = (e_res[i] == '0);
          end
        end
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  initial forever begin
    @(negedge clk_i);
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d valid_o", i), vout[i], e_valid[i]);
        check($sformatf("u%0d ready_o", i), ready[i], !m_mul[i]);
        check($sformatf("u%0d busy_o", i), busy[i], m_mul[i]);
        check($sformatf("u%0d result_o", i), res[i], e_res[i]);
        check($sformatf("u%0d zero_o", i), zero[i], e_zero[i]);
      end
    end
  end

  // Record every result pulse from the early-exit instance.
  initial forever begin
    @(negedge clk_i);
    if (vout[1]) log_q.push_back(res[1]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic offer(input int d, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, output int acc_cyc);
    op = o; a = x; b = y; vin[d] = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_i);
      if (ready[d]) begin
        @(posedge clk_i); #1;
        vin[d] = 1'b0;
        acc_cyc = cyc;
        return;
      end
    end
    tests++; fails++;
    $display("FAIL offer timeout: u%0d never ready, got 0, expected 1", d);
    vin[d] = 1'b0;
    acc_cyc = -1;
  endtask

  task automatic wait_valid(input int d, output int n, output int low);
    n = 0; low = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i);
      n++;
      if (vout[d]) return;
      if (!ready[d]) low++;
    end
    n = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [3:0] ops [8] = '{C_AND, C_ADD, C_XOR, C_SLL, C_SRA, C_SUB, C_MUL, C_BAD};

  initial begin
    int n, low, t0, t1, t2;
    #1 rst_i = 1'b0;
    #3;
    for (int i = 0; i < 2; i++) begin
      check("reset ready_o", ready[i], 1);
      check("reset valid_o", vout[i], 0);
      check("reset busy_o", busy[i], 0);
      check("reset result_o", res[i], 0);
      check("reset zero_o", zero[i], 0);
    end
    repeat (2) @(negedge clk_i);
    #2 rst_i = 1'b1;
    @(posedge clk_i); #1;

    offer(0, C_ADD, 32'h7FFF_FFFF, 32'h1, t0);
    wait_valid(0, n, low);
    check("add latency", n, 1);
    check("add result", res[0], 32'h8000_0000);
    check("add zero", zero[0], 0);

    offer(0, C_SUB, 32'd5, 32'd5, t0);
    wait_valid(0, n, low);
    check("sub result", res[0], 0);
    check("sub zero", zero[0], 1);

    offer(0, C_SRA, 32'h8000_0000, 32'h24, t0);
    wait_valid(0, n, low);
    check("sra result", res[0], 32'hF800_0000);

    offer(0, C_SLL, 32'h1, 32'd31, t0);
    wait_valid(0, n, low);
    check("sll result", res[0], 32'h8000_0000);

    offer(0, C_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F, t0);
    wait_valid(0, n, low);
    check("xor result", res[0], 32'hF00F_F00F);

    offer(0, C_BAD, 32'h1234, 32'h5678, t0);
    wait_valid(0, n, low);
    check("bad-op result", res[0], 0);
    check("bad-op zero", zero[0], 1);

    offer(0, C_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t0);
    wait_valid(0, n, low);
    check("mul full latency", n, 33);
    check("mul full ready low", low, 32);
    check("mul full result", res[0], 32'h1);
    check("mul full zero", zero[0], 0);

    offer(1, C_MUL, 32'd12, 32'd0, t0);
    wait_valid(1, n, low);
    check("mul x0 latency", n, 2);
    check("mul x0 result", res[1], 0);
    check("mul x0 zero", zero[1], 1);

    @(posedge clk_i); #1;
    log_q.delete();
    offer(1, C_ADD, 32'd10, 32'd20, t0);
    offer(1, C_MUL, 32'd3, 32'd7, t1);
    offer(1, C_ADD, 32'd1, 32'd1, t2);
    repeat (4) @(negedge clk_i);
    check("b2b mul accept gap", t1 - t0, 1);
    check("b2b add2 accept gap", t2 - t1, 4);
    check("b2b pulse count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("b2b add1 result", log_q[0], 30);
      check("b2b mul result", log_q[1], 21);
      check("b2b add2 result", log_q[2], 2);
    end

    @(posedge clk_i); #1;
    offer(1, C_MUL, 32'd100, 32'd200, t0);
    repeat (4) @(posedge clk_i);
    #1 flush = 1'b1;
    @(posedge clk_i); #1 flush = 1'b0;
    check("flush ready_o", ready[1], 1);
    check("flush valid_o", vout[1], 0);
    check("flush result held", res[1], 2);
    log_q.delete();
    repeat (12) @(negedge clk_i);
    check("flush no pulse", log_q.size(), 0);

    @(posedge clk_i); #1;
    offer(0, C_MUL, 32'h1234, 32'h5678, t0);
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("async rst busy_o", busy[0], 0);
    check("async rst ready_o", ready[0], 1);
    check("async rst valid_o", vout[0], 0);
    check("async rst result_o", res[0], 0);
    check("async rst zero_o", zero[0], 0);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    @(posedge clk_i); #1;
    offer(0, C_ADD, 32'd2, 32'd3, t0);
    wait_valid(0, n, low);
    check("post-reset add latency", n, 1);
    check("post-reset add result", res[0], 5);

    for (int it = 0; it < 600; it++) begin
      int d, r;
      logic [3:0] o;
      logic [W-1:0] x, y;
      d = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      o = ($urandom_range(0, 3) == 0) ? C_MUL : ops[$urandom_range(0, 7)];
      x = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
      y = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
      if (r == 0) begin
        op = o; a = x; b = y; vin[d] = 1'b1; flush = 1'b1;
        @(posedge clk_i); #1;
        flush = 1'b0; vin[d] = 1'b0;
      end else if (r == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk_i);
        #1;
      end else begin
        offer(d, o, x, y, t0);
      end
    end
    repeat (40) @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU. Consumes the 4-bit ALU control code produced by ALU control, plus two 32-bit operands from the ID/EX register.
- Produces a registered result and a zero flag for beq.
- Single-cycle ops (ADD, SUB, AND, XOR, SLL, SRA) have 1-cycle latency.
- MUL runs on an iterative radix-2 shift-add engine. It holds off upstream via ready_o, and the hazard unit uses it as a stall source.

Parameters:
- WIDTH, 32, operand/result width.
- MUL_EARLY_EXIT, 1, when 1 the multiplier finishes as soon as the remaining multiplier bits are all zero.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- valid_i  input  1  operation offered this cycle.
- ready_o  output  1  unit can accept an operation this cycle.
- ALUCtl_i  input  4  operation code, `ALU_CTL_* encodings from Const.v.
- data1_i  input  WIDTH  operand A (rs1).
- data2_i  input  WIDTH  operand B (rs2 or immediate).
- flush_i  input  1  abort any in-flight operation (branch/flush).
- valid_o  output  1  one-cycle pulse: result_o/zero_o are valid.
- result_o  output  WIDTH  registered result.
- zero_o  output  1  registered (result == 0).
- busy_o  output  1  multiplier engine active; feeds the stall logic.

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE.
  - valid_o=0, result_o=0, zero_o=0, busy_o=0, ready_o=1.
  - Counter and operand registers cleared.
- States: IDLE, MUL.
- ready_o = (state==IDLE). Accept = valid_i & ready_o & ~flush_i.
- IDLE, accept, non-MUL op: next edge drives result_o = f(A,B), zero_o = (f==0), valid_o=1. Latency 1 cycle. Back-to-back accepts every cycle are allowed.
- Op semantics:
  - ADD: A+B mod 2^WIDTH.
  - SUB: A-B mod 2^WIDTH.
  - AND: A&B. XOR: A^B.
  - SLL: A << B[4:0].
  - SRA: $signed(A) >>> B[4:0], sign-filled.
  - Any other code: result 0, zero_o=1, 1-cycle latency.
- IDLE, accept, MUL:
  - Latch multiplicand=A, multiplier=B, acc=0, cnt=0. Go to MUL. busy_o=1, ready_o=0, valid_o=0.
- MUL, each cycle:
  - If multiplier[0], acc += multiplicand.
  - multiplicand <<= 1, multiplier >>= 1 (logical), cnt++.
- MUL completes when cnt reaches WIDTH, or when MUL_EARLY_EXIT=1 and the shifted multiplier is zero (checked after each update).
  - On completion: result_o = acc (low WIDTH bits, signed/unsigned identical), zero_o = (acc==0), valid_o=1 for one cycle, state=IDLE, busy_o=0.
  - Fixed latency with MUL_EARLY_EXIT=0: WIDTH+1 cycles from accept to valid_o.
  - Multiplier=0 at accept with early exit: completes after 1 MUL cycle (latency 2).
- The cycle after MUL completion: ready_o=1, and a new accept is legal in that same cycle.
- valid_i while ready_o=0: ignored. Upstream holds op and operands stable until accepted.
- flush_i=1:
  - In MUL: return to IDLE next edge, valid_o stays 0, result_o/zero_o unchanged.
  - In IDLE: any concurrent valid_i is not accepted, and the valid_o that the next edge would otherwise raise is suppressed.
- result_o/zero_o hold their last value when valid_o=0.
- Async reset mid-MUL: immediate return to reset values. No result is ever emitted for the aborted op.

Test Plan:
- ADD 0x7FFFFFFF + 1 -> valid_o next cycle, result 0x80000000, zero_o=0. SUB 5-5 -> result 0, zero_o=1.
- SRA 0x80000000 by data2=0x24 (shamt 4) -> 0xF8000000. SLL 1 by 31 -> 0x80000000. XOR 0xFF00FF00^0x0F0F0F0F -> 0xF00FF00F.
- MUL 0xFFFFFFFF * 0xFFFFFFFF, MUL_EARLY_EXIT=0 -> ready_o low 32 cycles, valid_o at accept+33, result 0x00000001. MUL 12*0 with early exit -> valid_o at accept+2, result 0, zero_o=1.
- Back-to-back ADD, MUL(3*7), ADD offered continuously -> ADD result at +1; second ADD stalled until MUL done (21 emitted); ADD accepted the cycle after, exactly 3 valid_o pulses total.
- flush_i asserted 5 cycles into MUL(100*200) -> no valid_o, ready_o=1 next cycle, result_o retains the previous value.
- rst_i driven low asynchronously mid-MUL between clock edges -> all outputs reset immediately. After release, ADD 2+3 -> result 5 with 1-cycle latency.
